// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: valid/ready FIFO over a single-port 1-cycle-latency synchronous RAM with a registered head word.
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH = CW'(2 ** ADDR_WIDTH);
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         ram_count_q, ram_count_d;
  logic                  fetch_pending_q, fetch_pending_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  fetch, push;
  // Fetch wins the RAM port; ram_q is only sampled the cycle after a fetch, so post-write high-Z is never seen.
  always_comb begin
    full            = ram_count_q == DEPTH;
    fetch           = ram_count_q != '0 && !fetch_pending_q && (!rd_valid_q || rd_ready);
    wr_ready        = !rst && !full && !fetch;
    push            = wr_valid && wr_ready;
    ram_we          = push;
    ram_address     = push ? wr_ptr_q : rd_ptr_q;
    ram_d           = push ? wr_data : '0;
    wr_ptr_d        = push ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d        = fetch ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    ram_count_d     = push ? ram_count_q + CW'(1) : fetch ? ram_count_q - CW'(1) : ram_count_q;
    fetch_pending_d = fetch;
    rd_valid_d      = fetch_pending_q || (rd_valid_q && !rd_ready);
    rd_data_d       = fetch_pending_q ? ram_q : rd_data_q;
    count           = ram_count_q + CW'(fetch_pending_q) + CW'(rd_valid_q);
    empty           = count == '0;
    rd_valid        = rd_valid_q;
    rd_data         = rd_data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      ram_count_q     <= '0;
      fetch_pending_q <= 1'b0;
      rd_valid_q      <= 1'b0;
      rd_data_q       <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      ram_count_q     <= ram_count_d;
      fetch_pending_q <= fetch_pending_d;
      rd_valid_q      <= rd_valid_d;
      rd_data_q       <= rd_data_d;
    end
  end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: single-word vector table plus fill/drain/contention/async-reset sequences against a RAM model.
module tb_ram_fifo_ctrl;
  logic        clk = 1'b0, rst = 1'b1, wr_valid = 1'b0, rd_ready = 1'b0;
  logic [31:0] wr_data = '0, rd_data, ram_d, ram_q;
  logic        wr_ready, rd_valid, full, empty, ram_we;
  logic [7:0]  count;
  logic [6:0]  ram_address;
  logic [31:0] mem [128];
  int          checks = 0, errors = 0;
  logic [31:0] sb [$];
  int          m_ram = 0, m_wp = 0, m_rp = 0, last_fa = -1, n_pops = 0;
  logic        m_pend = 1'b0, m_val = 1'b0, saw_wrap = 1'b0;

  ram_fifo_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .count(count),
    .full(full), .empty(empty), .ram_we(ram_we), .ram_address(ram_address),
    .ram_d(ram_d), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // RAM model: q is registered; the post-write high-Z is modeled as a poison word.
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_address] <= ram_d;
      ram_q <= 32'hBAD0_BAD0;
    end else ram_q <= mem[ram_address];
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic int mcount();
    return m_ram + int'(m_pend) + int'(m_val);
  endfunction

  function automatic void model_reset();
    m_ram = 0; m_wp = 0; m_rp = 0; m_pend = 1'b0; m_val = 1'b0;
    last_fa = -1; saw_wrap = 1'b0;
    sb.delete();
  endfunction

  // One cycle: drive after the falling edge, check against the model, then advance the model.
  task automatic step(input logic wv, input logic rr, input logic [31:0] wd, output logic acc);
    logic f, wrr, psh, pp;
    logic [31:0] e;
    @(negedge clk);
    wr_valid = wv; rd_ready = rr; wr_data = wd;
    #1;
    f   = m_ram != 0 && !m_pend && (!m_val || rr);
    wrr = m_ram != 128 && !f;
    psh = wv && wrr;
    pp  = m_val && rr;
    chk("wr_ready", 64'(wr_ready), 64'(wrr));
    chk("ram_we", 64'(ram_we), 64'(psh));
    chk("ram_address", 64'(ram_address), 64'(psh ? m_wp : m_rp));
    if (psh) chk("ram_d", 64'(ram_d), 64'(wd));
    chk("rd_valid", 64'(rd_valid), 64'(m_val));
    chk("count", 64'(count), 64'(mcount()));
    chk("full", 64'(full), 64'(m_ram == 128));
    chk("empty", 64'(empty), 64'(mcount() == 0));
    if (pp) begin
      e = (sb.size() != 0) ? sb.pop_front() : 32'h0;
      chk("rd_data", 64'(rd_data), 64'(e));
      n_pops++;
    end
    if (psh) sb.push_back(wd);
    if (f) begin
      if (last_fa == 127 && ram_address == 7'd0) saw_wrap = 1'b1;
      last_fa = int'(ram_address);
    end
    m_wp   = (m_wp + int'(psh)) % 128;
    m_rp   = (m_rp + int'(f)) % 128;
    m_ram  = m_ram + int'(psh) - int'(f);
    m_val  = m_pend ? 1'b1 : (pp ? 1'b0 : m_val);
    m_pend = f;
    acc    = psh;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_valid = 1'b1; rd_ready = 1'b1;
    #1;
    chk("rst_wr_ready", 64'(wr_ready), 64'(0));
    chk("rst_ram_we", 64'(ram_we), 64'(0));
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full", 64'(full), 64'(0));
    @(negedge clk);
    rst = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic wv, rr; logic [31:0] wd;
    logic wrr, we; logic [6:0] addr; logic rv; logic [31:0] rdat; logic [7:0] cnt; logic emp;
  } vec_t;
  vec_t tbl [8];

  initial begin
    logic acc;
    int   nxt, base;
    // Single word: push at t, fetch at t+1, capture end of t+2, visible t+3, held until popped.
    tbl[0] = '{1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 7'd0, 1'b0, 32'h0, 8'd0, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 7'd0, 1'b0, 32'h0, 8'd1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 7'd1, 1'b0, 32'h0, 8'd1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 7'd1, 1'b1, 32'hDEADBEEF, 8'd1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 7'd1, 1'b1, 32'hDEADBEEF, 8'd1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 7'd1, 1'b1, 32'hDEADBEEF, 8'd1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 7'd1, 1'b0, 32'h0, 8'd0, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 7'd1, 1'b0, 32'h0, 8'd0, 1'b1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wr_valid = tbl[i].wv; rd_ready = tbl[i].rr; wr_data = tbl[i].wd;
      #1;
      chk($sformatf("t%0d_wr_ready", i), 64'(wr_ready), 64'(tbl[i].wrr));
      chk($sformatf("t%0d_ram_we", i), 64'(ram_we), 64'(tbl[i].we));
      chk($sformatf("t%0d_ram_address", i), 64'(ram_address), 64'(tbl[i].addr));
      chk($sformatf("t%0d_rd_valid", i), 64'(rd_valid), 64'(tbl[i].rv));
      if (tbl[i].rv) chk($sformatf("t%0d_rd_data", i), 64'(rd_data), 64'(tbl[i].rdat));
      chk($sformatf("t%0d_count", i), 64'(count), 64'(tbl[i].cnt));
      chk($sformatf("t%0d_empty", i), 64'(empty), 64'(tbl[i].emp));
    end

    // Fill 129 incrementing words, then confirm further pushes are refused.
    do_reset();
    nxt = 0;
    for (int i = 0; i < 400 && nxt < 129; i++) begin
      step(1'b1, 1'b0, 32'(nxt), acc);
      if (acc) nxt++;
    end
    step(1'b1, 1'b0, 32'(nxt), acc);
    chk("fill_full", 64'(full), 64'(1));
    chk("fill_count", 64'(count), 64'(129));
    chk("fill_wr_ready", 64'(wr_ready), 64'(0));
    chk("fill_ram_we", 64'(ram_we), 64'(0));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'hFFFF_0000, acc);

    // Drain across the pointer wrap; the scoreboard checks 0..128 in order.
    base = n_pops;
    for (int i = 0; i < 600 && mcount() != 0; i++) step(1'b0, 1'b1, 32'h0, acc);
    chk("drain_pops", 64'(n_pops - base), 64'(129));
    chk("drain_addr_wrap", 64'(saw_wrap), 64'(1));
    step(1'b0, 1'b0, 32'h0, acc);
    chk("drain_empty", 64'(empty), 64'(1));
    chk("drain_count", 64'(count), 64'(0));

    // Contention: both sides always requesting for 300 popped words.
    base = n_pops;
    for (int i = 0; i < 2000 && n_pops - base < 300; i++) step(1'b1, 1'b1, $urandom, acc);
    chk("cont_pops", 64'(n_pops - base), 64'(300));
    for (int i = 0; i < 600 && mcount() != 0; i++) step(1'b0, 1'b1, 32'h0, acc);

    // Asynchronous reset with count=50 and a fetch in flight.
    do_reset();
    for (int i = 0; i < 200 && mcount() != 51; i++) step(1'b1, 1'b0, $urandom, acc);
    step(1'b0, 1'b1, 32'h0, acc);
    @(negedge clk);
    wr_valid = 1'b1; rd_ready = 1'b0;
    #1;
    chk("pre_rst_count", 64'(count), 64'(50));
    chk("pre_rst_rd_valid", 64'(rd_valid), 64'(0));
    #2 rst = 1'b1;
    #1;
    chk("arst_wr_ready", 64'(wr_ready), 64'(0));
    chk("arst_ram_we", 64'(ram_we), 64'(0));
    chk("arst_rd_valid", 64'(rd_valid), 64'(0));
    chk("arst_count", 64'(count), 64'(0));
    chk("arst_empty", 64'(empty), 64'(1));
    chk("arst_full", 64'(full), 64'(0));
    @(negedge clk);
    rst = 1'b0; wr_valid = 1'b0;
    model_reset();
    step(1'b1, 1'b0, 32'h12345678, acc);
    chk("post_rst_push", 64'(acc), 64'(1));
    step(1'b0, 1'b0, 32'h0, acc);
    step(1'b0, 1'b0, 32'h0, acc);
    step(1'b0, 1'b0, 32'h0, acc);
    chk("lat_rd_valid", 64'(rd_valid), 64'(1));
    chk("lat_rd_data", 64'(rd_data), 64'h12345678);
    step(1'b0, 1'b1, 32'h0, acc);
    step(1'b0, 1'b0, 32'h0, acc);
    chk("final_empty", 64'(empty), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

FIFO controller that turns the team's 128x32 single-port synchronous RAM into a first-in/first-out buffer with valid/ready handshakes on both sides. It sits directly upstream of that RAM and drives its `we`, `address` and `d` inputs. It consumes the RAM's registered `q` output, which has one-cycle read latency and goes high-Z in the cycle after a write. The block arbitrates the single RAM port between pushes and prefetches and holds the head word in a local output register.

## Interface
- `DATA_WIDTH`, 32, word width; must match the RAM.
- `ADDR_WIDTH`, 7, RAM address bits; DEPTH = 2**ADDR_WIDTH = 128.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_valid`  in  1  push request.
- `wr_ready`  out  1  push accepted when `wr_valid && wr_ready`.
- `wr_data`  in  DATA_WIDTH  push word.
- `rd_valid`  out  1  `rd_data` holds the FIFO head.
- `rd_ready`  in  1  pop when `rd_valid && rd_ready`.
- `rd_data`  out  DATA_WIDTH  head word (registered).
- `count`  out  ADDR_WIDTH+1  total words held (RAM + in-flight + output reg), 0..129.
- `full`  out  1  RAM region holds DEPTH words.
- `empty`  out  1  `count == 0`.
- `ram_we`  out  1  to RAM `we`.
- `ram_address`  out  ADDR_WIDTH  to RAM `address`.
- `ram_d`  out  DATA_WIDTH  to RAM `d`.
- `ram_q`  in  DATA_WIDTH  from RAM `q`.

## Operation
- State registers:
  - `wr_ptr`, `rd_ptr` (ADDR_WIDTH bits, wrap modulo DEPTH).
  - `ram_count` (0..DEPTH).
  - `fetch_pending` (1 bit).
  - `rd_valid`, `rd_data`.
- Fetch condition, combinational, evaluated each cycle:
  - fetch = `ram_count != 0 && !fetch_pending && (!rd_valid || rd_ready)`.
  - Fetch has priority over push on the RAM port.
- `wr_ready = !rst && !full && !fetch`. This is a combinational path from `rd_ready` to `wr_ready` and is intentional.
- Push cycle (`wr_valid && wr_ready`):
  - RAM drive: `ram_we=1`, `ram_address=wr_ptr`, `ram_d=wr_data`.
  - Register updates: `wr_ptr+1`, `ram_count+1`.
- Fetch cycle:
  - RAM drive: `ram_we=0`, `ram_address=rd_ptr`.
  - Register updates: `rd_ptr+1`, `ram_count-1`, `fetch_pending<=1`.
- Idle cycle: `ram_we=0`, `ram_address=rd_ptr`, `ram_d=0`.
- Capture: in any cycle with `fetch_pending=1`, `rd_data<=ram_q`, `rd_valid<=1`, `fetch_pending<=0`. `ram_q` is sampled only in these cycles, so the post-write high-Z is never captured.
- Pop without a capture in the same cycle: `rd_valid<=0`, and `rd_data` holds its value.
- `fetch_pending` and `rd_valid` are never both 1.
- Flags:
  - `count = ram_count + fetch_pending + rd_valid`; maximum total capacity is 129.
  - `full = (ram_count == DEPTH)`.
  - `empty = (count == 0)`.
- No bypass: a word pushed in cycle t is not fetched in cycle t.

## Timing
- Reset (asynchronous, while `rst=1`):
  - Pointers, `ram_count`, `fetch_pending`, `rd_valid` = 0; `rd_data` = 0.
  - Outputs: `wr_ready=0`, `ram_we=0`, `count=0`, `full=0`, `empty=1`.
- Reset mid-operation discards all contents immediately. RAM contents are not cleared; they become unreachable.
- First-word latency: push accepted in cycle t, fetch in t+1, capture at the end of t+2, `rd_valid=1` in t+3.
- Read throughput is at most one word per 2 cycles (fetch, capture).
- Write throughput is 1 word/cycle while no fetch is needed.
- Under continuous traffic, a push stall is required on every fetch cycle.
- Full: `wr_ready=0`. A pop that triggers a fetch frees one RAM entry, and `full` drops the following cycle.
- Empty: `rd_valid=0`, and `rd_ready` is ignored.
- Pointer wrap-around from 127 to 0 is seamless, and order is preserved across the wrap.
- `rd_data`/`rd_valid` are stable while `rd_valid && !rd_ready`.

## Test plan
- Reset: assert `rst` with `wr_valid=1` → `wr_ready=0`, `ram_we=0`, `rd_valid=0`, `count=0`, `empty=1`, `full=0`.
- Single word: push 0xDEADBEEF in cycle t with `rd_ready=0`.
  - Cycle t: `ram_we=1` at address 0.
  - Cycle t+1: fetch read at address 0.
  - From cycle t+3: `rd_valid=1`, `rd_data=0xDEADBEEF`, and both hold until `rd_ready`. After the pop, `empty=1`.
- Fill: push 129 incrementing words (0..128) with `rd_ready=0`.
  - `full=1`, `count=129`, `wr_ready=0`.
  - Further pushes are refused, and `ram_we` stays 0.
- Drain with wrap-around: pop all 129 words. Data comes out 0..128 in order, and `ram_address` wraps 127→0. End state: `count=0`, `empty=1`.
- Contention: hold `wr_valid=1` and `rd_ready=1` with a non-empty FIFO.
  - `wr_ready` is low exactly on fetch cycles.
  - `ram_we` and a fetch never occur in the same cycle.
  - Output order matches input order across 300 words.
- Mid-operation reset: assert `rst` asynchronously (off the clock edge) with `count=50` and `fetch_pending=1`.
  - Outputs take their reset values immediately.
  - After release, a push of 0x12345678 is read back correctly with 3-cycle latency.
